// File: rtl/qc_pkg.sv
// Shared types and helpers for the state-vector gate engine.
// Amplitudes are signed fixed point with FRAC_W fractional bits.
package qc_pkg;

  localparam int unsigned AMP_W  = 19;
  localparam int unsigned FRAC_W = 16;
  localparam int unsigned GATE_W = 5;
  localparam int unsigned PROD_W = 2 * AMP_W;
  // Two guard bits cover the four-term sum of full-width products
  localparam int unsigned SUM_W  = PROD_W + 2;

  typedef logic signed [AMP_W-1:0] amp_t;

  typedef struct packed {
    amp_t re;
    amp_t im;
  } cplx_t;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StMtLo,
    StMtHi,
    StRd0,
    StRd1,
    StCap,
    StMul,
    StWr0,
    StWr1,
    StFin
  } state_e;

  localparam logic signed [SUM_W-1:0] AMP_MAX_X = SUM_W'(2 ** (AMP_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] AMP_MIN_X = SUM_W'(-(2 ** (AMP_W - 1)));

  function automatic amp_t sat_amp(input logic signed [SUM_W-1:0] v);
    if (v > AMP_MAX_X) begin
      sat_amp = AMP_MAX_X[AMP_W-1:0];
    end else if (v < AMP_MIN_X) begin
      sat_amp = AMP_MIN_X[AMP_W-1:0];
    end else begin
      sat_amp = v[AMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/complex_dot2.sv
// Combinational complex dot product y = m0*x0 + m1*x1, rescaled by FRAC_W
// (arithmetic shift, truncation toward -inf) and saturated to an amplitude.
module complex_dot2
  import qc_pkg::*;
(
  input  cplx_t m0,
  input  cplx_t m1,
  input  cplx_t x0,
  input  cplx_t x1,
  output cplx_t y
);

  logic signed [PROD_W-1:0] p_rr0, p_ii0, p_ri0, p_ir0;
  logic signed [PROD_W-1:0] p_rr1, p_ii1, p_ri1, p_ir1;
  logic signed [SUM_W-1:0]  s_re, s_im;

  always_comb begin
    p_rr0 = $signed(m0.re) * $signed(x0.re);
    p_ii0 = $signed(m0.im) * $signed(x0.im);
    p_ri0 = $signed(m0.re) * $signed(x0.im);
    p_ir0 = $signed(m0.im) * $signed(x0.re);
    p_rr1 = $signed(m1.re) * $signed(x1.re);
    p_ii1 = $signed(m1.im) * $signed(x1.im);
    p_ri1 = $signed(m1.re) * $signed(x1.im);
    p_ir1 = $signed(m1.im) * $signed(x1.re);
    s_re  = SUM_W'(p_rr0) - SUM_W'(p_ii0) + SUM_W'(p_rr1) - SUM_W'(p_ii1);
    s_im  = SUM_W'(p_ri0) + SUM_W'(p_ir0) + SUM_W'(p_ri1) + SUM_W'(p_ir1);
    y.re  = sat_amp(s_re >>> FRAC_W);
    y.im  = sat_amp(s_im >>> FRAC_W);
  end

endmodule

// File: rtl/qubit_gate_apply.sv
// Applies one single-qubit 2x2 complex gate to the state-vector RAM: fetches the
// matrix from the matrix table, then rewrites every amplitude pair split by `target`.
module qubit_gate_apply
  import qc_pkg::*;
#(
  parameter  int unsigned NUM_QUBITS = 4,
  localparam int unsigned QB_W       = $clog2(NUM_QUBITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [GATE_W-1:0]     gate,
  input  logic [QB_W-1:0]       target,
  output logic                  busy,
  output logic                  done,
  output logic [GATE_W-1:0]     mt_gate,
  output logic                  mt_ready,
  input  logic                  mt_done,
  input  amp_t [0:1][0:1][0:1]  mt_result,
  output logic [NUM_QUBITS-1:0] sv_addr,
  input  amp_t                  sv_rdata_re,
  input  amp_t                  sv_rdata_im,
  output logic                  sv_we,
  output amp_t                  sv_wdata_re,
  output amp_t                  sv_wdata_im
);

  state_e                  state_q, state_d;
  logic [GATE_W-1:0]       gate_q;
  logic [QB_W-1:0]         tgt_q;
  logic [NUM_QUBITS-2:0]   k_q;
  logic                    k_last;
  logic [NUM_QUBITS-1:0]   k_ext, low_mask, tbit, i0, i1;

  cplx_t mat_q [0:1][0:1];
  cplx_t a0_q, a1_q, b0_q, b1_q, b0_d, b1_d;

  assign k_last = (k_q == '1);

  // Insert a zero at bit `target` of k to form the lower pair address
  always_comb begin
    k_ext    = {1'b0, k_q};
    tbit     = NUM_QUBITS'(1) << tgt_q;
    low_mask = tbit - NUM_QUBITS'(1);
    i0       = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    i1       = i0 | tbit;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   state_d = StMtLo;
      StMtLo:  if (!mt_done) state_d = StMtHi;
      StMtHi:  if (mt_done) state_d = StRd0;
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StCap;
      StCap:   state_d = StMul;
      StMul:   state_d = StWr0;
      StWr0:   state_d = StWr1;
      StWr1:   state_d = k_last ? StFin : StRd0;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gate_q  <= '0;
      tgt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        gate_q <= gate;
        tgt_q  <= target;
      end
      if (state_q == StMtHi && mt_done) begin
        k_q <= '0;
      end else if (state_q == StWr1) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // Datapath registers carry no reset; every use is preceded by a load
  always_ff @(posedge clk) begin
    if (state_q == StMtHi && mt_done) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          mat_q[r][c].re <= mt_result[r][c][0];
          mat_q[r][c].im <= mt_result[r][c][1];
        end
      end
    end
    if (state_q == StRd1) a0_q <= '{re: sv_rdata_re, im: sv_rdata_im};
    if (state_q == StCap) a1_q <= '{re: sv_rdata_re, im: sv_rdata_im};
    if (state_q == StMul) begin
      b0_q <= b0_d;
      b1_q <= b1_d;
    end
  end

  complex_dot2 u_dot_b0 (
    .m0 (mat_q[0][0]),
    .m1 (mat_q[0][1]),
    .x0 (a0_q),
    .x1 (a1_q),
    .y  (b0_d)
  );

  complex_dot2 u_dot_b1 (
    .m0 (mat_q[1][0]),
    .m1 (mat_q[1][1]),
    .x0 (a0_q),
    .x1 (a1_q),
    .y  (b1_d)
  );

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFin);
    mt_ready    = (state_q == StReq);
    mt_gate     = gate_q;
    sv_we       = 1'b0;
    sv_addr     = '0;
    sv_wdata_re = '0;
    sv_wdata_im = '0;
    unique case (state_q)
      StRd0: sv_addr = i0;
      StRd1: sv_addr = i1;
      StWr0: begin
        sv_we       = 1'b1;
        sv_addr     = i0;
        sv_wdata_re = b0_q.re;
        sv_wdata_im = b0_q.im;
      end
      StWr1: begin
        sv_we       = 1'b1;
        sv_addr     = i1;
        sv_wdata_re = b1_q.re;
        sv_wdata_im = b1_q.im;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == StIdle && start) begin
      assert (int'(target) < int'(NUM_QUBITS))
        else $error("qubit_gate_apply: target out of range");
    end
  end

endmodule

// File: tb/tb_qubit_gate_apply.sv
// Directed bench for qubit_gate_apply with behavioural matrix-table and state-RAM models.
module tb_qubit_gate_apply;
  import qc_pkg::*;

  localparam int NQ    = 4;
  localparam int ONE   = 65536;
  localparam int HV    = 46341;
  localparam int TWO   = 131072;
  localparam int THREE = 196608;
  localparam int AMAX  = 262143;
  localparam int AMIN  = -262144;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0] gate = '0;
  logic [1:0] target = '0;
  logic busy, done, mt_ready, mt_done, sv_we;
  logic [4:0] mt_gate;
  amp_t [0:1][0:1][0:1] mt_result;
  logic [3:0] sv_addr;
  amp_t sv_rdata_re, sv_rdata_im, sv_wdata_re, sv_wdata_im;

  always #5 clk = ~clk;

  qubit_gate_apply #(.NUM_QUBITS(NQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .gate        (gate),
    .target      (target),
    .busy        (busy),
    .done        (done),
    .mt_gate     (mt_gate),
    .mt_ready    (mt_ready),
    .mt_done     (mt_done),
    .mt_result   (mt_result),
    .sv_addr     (sv_addr),
    .sv_rdata_re (sv_rdata_re),
    .sv_rdata_im (sv_rdata_im),
    .sv_we       (sv_we),
    .sv_wdata_re (sv_wdata_re),
    .sv_wdata_im (sv_wdata_im)
  );

  // Matrix table: done drops the cycle after ready, rises two cycles later
  int cur_m [8];
  int mt_cnt;
  for (genvar i = 0; i < 8; i++) begin : g_mt
    assign mt_result[i/4][(i/2)%2][i%2] = amp_t'(cur_m[i]);
  end
  always @(posedge clk) begin
    if (reset) begin
      mt_done <= 1'b1;
      mt_cnt  <= 0;
    end else if (mt_ready) begin
      mt_done <= 1'b0;
      mt_cnt  <= 2;
    end else if (mt_cnt != 0) begin
      mt_cnt <= mt_cnt - 1;
      if (mt_cnt == 1) mt_done <= 1'b1;
    end
  end

  // State RAM with 1-cycle read and a bench load port
  amp_t mem_re [16];
  amp_t mem_im [16];
  logic ld_en = 1'b0;
  logic [3:0] ld_idx = '0;
  amp_t ld_re = '0, ld_im = '0;
  always @(posedge clk) begin
    sv_rdata_re <= mem_re[sv_addr];
    sv_rdata_im <= mem_im[sv_addr];
    if (ld_en) begin
      mem_re[ld_idx] <= ld_re;
      mem_im[ld_idx] <= ld_im;
    end else if (sv_we) begin
      mem_re[sv_addr] <= sv_wdata_re;
      mem_im[sv_addr] <= sv_wdata_im;
    end
  end

  int rdy_cnt = 0, we_cnt = 0, done_cnt = 0, busy_cnt = 0;
  logic [4:0] gate_at_req = '0;
  always @(negedge clk) begin
    if (mt_ready === 1'b1) begin
      rdy_cnt     <= rdy_cnt + 1;
      gate_at_req <= mt_gate;
    end
    if (sv_we === 1'b1) we_cnt <= we_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [4:0] g;
    int         t;
    int         m [8];
    int         ia, ia_re, ia_im;
    int         ib, ib_re, ib_im;
    int         ea_re, ea_im, eb_re, eb_im;
  } vec_t;

  vec_t vecs [8];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic load_ram(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en  = 1'b1;
      ld_idx = 4'(i);
      ld_re  = amp_t'((i == v.ia) ? v.ia_re : (i == v.ib) ? v.ib_re : 0);
      ld_im  = amp_t'((i == v.ia) ? v.ia_im : (i == v.ib) ? v.ib_im : 0);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_done(input int s_d);
    int guard = 0;
    while (done_cnt == s_d && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    repeat (2) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int s_r, s_w, s_d, s_b, others;
    load_ram(v);
    cur_m = v.m;
    @(negedge clk); #1;
    s_r = rdy_cnt; s_w = we_cnt; s_d = done_cnt; s_b = busy_cnt;
    start = 1'b1; gate = v.g; target = 2'(v.t);
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(s_d);
    chk({v.name, ".ready_pulses"}, rdy_cnt - s_r, 1);
    chk({v.name, ".done_pulses"}, done_cnt - s_d, 1);
    chk({v.name, ".we_cycles"}, we_cnt - s_w, 16);
    chk({v.name, ".busy_cycles"}, busy_cnt - s_b, 53);
    chk({v.name, ".mt_gate"}, int'(gate_at_req), int'(v.g));
    chk({v.name, ".a_re"}, int'(mem_re[v.ia]), v.ea_re);
    chk({v.name, ".a_im"}, int'(mem_im[v.ia]), v.ea_im);
    chk({v.name, ".b_re"}, int'(mem_re[v.ib]), v.eb_re);
    chk({v.name, ".b_im"}, int'(mem_im[v.ib]), v.eb_im);
    others = 0;
    for (int i = 0; i < 16; i++)
      if (i != v.ia && i != v.ib && (mem_re[i] != 0 || mem_im[i] != 0)) others++;
    chk({v.name, ".others_zero"}, others, 0);
  endtask

  initial begin
    int s_r, s_w, s_d, guard;
    // name, gate, target, m{00re,00im,01re,01im,10re,10im,11re,11im},
    // ia,re,im, ib,re,im, expected ia re/im, ib re/im
    vecs[0] = '{"x_t0", 5'd1, 0, '{0, 0, ONE, 0, ONE, 0, 0, 0},
                0, ONE, 0, 1, 0, 0, 0, 0, ONE, 0};
    // 46341*65536 >>> 16 = 46341
    vecs[1] = '{"h1_t2", 5'd2, 2, '{HV, 0, HV, 0, HV, 0, -HV, 0},
                0, ONE, 0, 4, 0, 0, HV, 0, HV, 0};
    // 2*46341^2 >>> 16 = 65536
    vecs[2] = '{"h2_t2", 5'd2, 2, '{HV, 0, HV, 0, HV, 0, -HV, 0},
                0, HV, 0, 4, HV, 0, ONE, 0, 0, 0};
    vecs[3] = '{"y_t3", 5'd3, 3, '{0, 0, 0, -ONE, 0, ONE, 0, 0},
                0, ONE, 0, 8, 0, 0, 0, 0, 0, ONE};
    vecs[4] = '{"sat_pos", 5'd4, 1, '{TWO, TWO, TWO, TWO, TWO, TWO, TWO, TWO},
                0, THREE, 0, 2, THREE, 0, AMAX, AMAX, AMAX, AMAX};
    vecs[5] = '{"sat_neg", 5'd4, 1, '{-TWO, -TWO, -TWO, -TWO, -TWO, -TWO, -TWO, -TWO},
                0, THREE, 0, 2, THREE, 0, AMIN, AMIN, AMIN, AMIN};
    // Last pair (k=7) with target 1: i0=13, i1=15
    vecs[6] = '{"x_t1_last", 5'd1, 1, '{0, 0, ONE, 0, ONE, 0, 0, 0},
                13, ONE, 0, 15, 0, 0, 0, 0, ONE, 0};
    // 0.5*(-3) floors to -2, 0.5*5 floors to 2
    vecs[7] = '{"trunc", 5'd5, 0, '{32768, 0, 0, 0, 0, 0, 0, 0},
                0, -3, 5, 1, 0, 0, -2, 2, 0, 0};
    for (int i = 0; i < 8; i++) cur_m[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.mt_ready", int'(mt_ready), 0);
    chk("rst.sv_we", int'(sv_we), 0);
    chk("rst.sv_addr", int'(sv_addr), 0);
    chk("rst.sv_wdata", int'(sv_wdata_re) | int'(sv_wdata_im), 0);
    chk("rst.mt_gate", int'(mt_gate), 0);
    reset = 1'b0;

    for (int n = 0; n < 8; n++) apply_vec(vecs[n]);

    // start held across REQ/MT_LO and pulsed mid-op; inputs and matrix change mid-op
    load_ram('{"ign", 5'd1, 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 2, ONE, 0, 0, 0, 0, 0, 0, 0, 0});
    cur_m = vecs[0].m;
    @(negedge clk); #1;
    s_r = rdy_cnt; s_w = we_cnt; s_d = done_cnt;
    start = 1'b1; gate = 5'd1; target = 2'd1;
    repeat (3) begin
      @(negedge clk); #1;
    end
    start = 1'b0; gate = 5'h1f; target = 2'd0;
    guard = 0;
    while (we_cnt == s_w && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 8; i++) cur_m[i] = 0;
    chk("ign.mt_gate_held", int'(mt_gate), 1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(s_d);
    chk("ign.ready_pulses", rdy_cnt - s_r, 1);
    chk("ign.we_cycles", we_cnt - s_w, 16);
    chk("ign.done_pulses", done_cnt - s_d, 1);
    chk("ign.amp0", int'(mem_re[0]), ONE);
    chk("ign.amp2", int'(mem_re[2]), 0);
    chk("ign.idle", int'(busy), 0);

    // reset during WR0 of pair 3 (seventh write cycle)
    load_ram(vecs[0]);
    cur_m = vecs[0].m;
    @(negedge clk); #1;
    s_w = we_cnt; s_d = done_cnt;
    start = 1'b1; gate = 5'd1; target = 2'd0;
    @(negedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (we_cnt - s_w < 7 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("mrst.reach_wr0", we_cnt - s_w, 7);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mrst.busy", int'(busy), 0);
    chk("mrst.sv_we", int'(sv_we), 0);
    chk("mrst.done", int'(done), 0);
    chk("mrst.mt_ready", int'(mt_ready), 0);
    chk("mrst.sv_addr", int'(sv_addr), 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    chk("mrst.no_done", done_cnt - s_d, 0);
    chk("mrst.no_more_we", we_cnt - s_w, 7);
    apply_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
